// File: rtl/wordle_board_ctrl.sv
// Wordle game-board controller: collects key events into a 6x5 letter grid,
// scores each submitted row against a latched target and drives the renderer bus.
module wordle_board_ctrl #(
    parameter int REJECT_CYCLES = 12_500_000
) (
    input  logic         dclk,
    input  logic         clr,
    input  logic         new_game,
    input  logic [24:0]  target,
    input  logic         key_valid,
    input  logic [4:0]   key_code,
    input  logic         key_back,
    input  logic         key_enter,
    output logic [209:0] display,
    output logic [2:0]   cur_row,
    output logic [2:0]   cur_col,
    output logic         busy,
    output logic         game_won,
    output logic         game_lost
);

    localparam logic [2:0] S_ENTRY  = 3'd0;
    localparam logic [2:0] S_REJECT = 3'd1;
    localparam logic [2:0] S_GREEN  = 3'd2;
    localparam logic [2:0] S_YELLOW = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_WON    = 3'd5;
    localparam logic [2:0] S_LOST   = 3'd6;

    localparam logic [6:0] BLANK_CELL = 7'h1A;
    localparam int         CW         = (REJECT_CYCLES > 1) ? $clog2(REJECT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(REJECT_CYCLES - 1);

    logic [2:0]    state_reg, state_next;
    logic [2:0]    row_reg, row_next;
    logic [2:0]    col_reg, col_next;
    logic [6:0]    cells_reg [0:29];
    logic [6:0]    cells_next [0:29];
    logic [24:0]   target_reg, target_next;
    logic [4:0]    consumed_reg, consumed_next;
    logic [4:0]    green_reg, green_next;
    logic [2:0]    yidx_reg, yidx_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          busy_reg, won_reg, lost_reg;

    logic [4:0] base_w;
    logic [4:0] guess_w [0:4];
    logic [4:0] match_w;
    logic [4:0] cand_w;
    logic [4:0] guess_cur_w;
    logic       found_w;
    logic [2:0] found_j_w;

    assign base_w      = 5'(row_reg) * 5'd5;
    assign guess_cur_w = guess_w[yidx_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 30; gi++) begin : g_disp
            assign display[7*gi +: 7] = cells_reg[gi];
        end
        for (gi = 0; gi < 5; gi++) begin : g_cmp
            assign guess_w[gi] = cells_reg[base_w + 5'(gi)][4:0];
            assign match_w[gi] = (guess_w[gi] == target_reg[5*gi +: 5]);
            assign cand_w[gi]  = !consumed_reg[gi] && (target_reg[5*gi +: 5] == guess_cur_w);
        end
    endgenerate

    // Lowest unconsumed target position matching the letter under yellow scan
    always_comb begin
        found_w   = 1'b0;
        found_j_w = 3'd0;
        for (int j = 4; j >= 0; j--) begin
            if (cand_w[j]) begin
                found_w   = 1'b1;
                found_j_w = 3'(j);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        cells_next    = cells_reg;
        target_next   = target_reg;
        consumed_next = consumed_reg;
        green_next    = green_reg;
        yidx_next     = yidx_reg;
        cnt_next      = cnt_reg;

        if (new_game) begin
            for (int i = 0; i < 30; i++) cells_next[i] = BLANK_CELL;
            state_next    = S_ENTRY;
            row_next      = 3'd0;
            col_next      = 3'd0;
            target_next   = target;
            consumed_next = 5'd0;
            green_next    = 5'd0;
            yidx_next     = 3'd0;
            cnt_next      = '0;
        end else begin
            case (state_reg)
                S_ENTRY: begin
                    if (key_enter) begin
                        if (col_reg == 3'd5) begin
                            consumed_next = 5'd0;
                            green_next    = 5'd0;
                            state_next    = S_GREEN;
                        end else begin
                            for (int c = 0; c < 5; c++) begin
                                if (3'(c) < col_reg) cells_next[base_w + 5'(c)][6:5] = 2'd3;
                            end
                            cnt_next   = CNT_LOAD;
                            state_next = S_REJECT;
                        end
                    end else if (key_back) begin
                        if (col_reg != 3'd0) begin
                            col_next = col_reg - 3'd1;
                            cells_next[base_w + 5'(col_reg - 3'd1)] = BLANK_CELL;
                        end
                    end else if (key_valid && key_code <= 5'd25 && col_reg < 3'd5) begin
                        cells_next[base_w + 5'(col_reg)] = {2'b00, key_code};
                        col_next = col_reg + 3'd1;
                    end
                end
                S_REJECT: begin
                    if (cnt_reg == '0) begin
                        // Unfilled cells of the row are already gray, so clear all five
                        for (int c = 0; c < 5; c++) cells_next[base_w + 5'(c)][6:5] = 2'd0;
                        state_next = S_ENTRY;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                S_GREEN: begin
                    for (int c = 0; c < 5; c++) begin
                        if (match_w[c]) cells_next[base_w + 5'(c)][6:5] = 2'd1;
                    end
                    green_next    = match_w;
                    consumed_next = match_w;
                    yidx_next     = 3'd0;
                    state_next    = S_YELLOW;
                end
                S_YELLOW: begin
                    if (!green_reg[yidx_reg] && found_w) begin
                        cells_next[base_w + 5'(yidx_reg)][6:5] = 2'd2;
                        consumed_next[found_j_w] = 1'b1;
                    end
                    if (yidx_reg == 3'd4) begin
                        state_next = S_CHECK;
                    end else begin
                        yidx_next = yidx_reg + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (green_reg == 5'b11111) begin
                        state_next = S_WON;
                    end else if (row_reg == 3'd5) begin
                        state_next = S_LOST;
                    end else begin
                        row_next   = row_reg + 3'd1;
                        col_next   = 3'd0;
                        state_next = S_ENTRY;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_reg    <= S_ENTRY;
            row_reg      <= 3'd0;
            col_reg      <= 3'd0;
            for (int i = 0; i < 30; i++) cells_reg[i] <= BLANK_CELL;
            target_reg   <= 25'd0;
            consumed_reg <= 5'd0;
            green_reg    <= 5'd0;
            yidx_reg     <= 3'd0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            won_reg      <= 1'b0;
            lost_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            for (int i = 0; i < 30; i++) cells_reg[i] <= cells_next[i];
            target_reg   <= target_next;
            consumed_reg <= consumed_next;
            green_reg    <= green_next;
            yidx_reg     <= yidx_next;
            cnt_reg      <= cnt_next;
            busy_reg     <= (state_next == S_REJECT) || (state_next == S_GREEN) ||
                            (state_next == S_YELLOW) || (state_next == S_CHECK);
            won_reg      <= (state_next == S_WON);
            lost_reg     <= (state_next == S_LOST);
        end
    end

    assign cur_row   = row_reg;
    assign cur_col   = col_reg;
    assign busy      = busy_reg;
    assign game_won  = won_reg;
    assign game_lost = lost_reg;

endmodule

// File: tb/tb_wordle_board_ctrl.sv
// Directed bench for wordle_board_ctrl: stimulus queues expected board snapshots,
// a monitor pops and compares them against the DUT outputs on the falling edge.
module tb_wordle_board_ctrl;

    logic         dclk = 1'b0;
    logic         clr;
    logic         new_game;
    logic [24:0]  target;
    logic         key_valid;
    logic [4:0]   key_code;
    logic         key_back;
    logic         key_enter;
    logic [209:0] display;
    logic [2:0]   cur_row;
    logic [2:0]   cur_col;
    logic         busy;
    logic         game_won;
    logic         game_lost;

    always #20 dclk = ~dclk;

    wordle_board_ctrl #(.REJECT_CYCLES(4)) dut (
        .dclk      (dclk),
        .clr       (clr),
        .new_game  (new_game),
        .target    (target),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_back  (key_back),
        .key_enter (key_enter),
        .display   (display),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy),
        .game_won  (game_won),
        .game_lost (game_lost)
    );

    typedef struct {
        string        name;
        logic [209:0] disp;
        logic [2:0]   row;
        logic [2:0]   col;
        logic         busy;
        logic         won;
        logic         lost;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] eb [0:29];
    int         total = 0;
    int         bad = 0;
    bit         done = 1'b0;

    function automatic logic [24:0] word(input logic [4:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic press_letter(input logic [4:0] k);
        key_code  = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press_back();
        key_back = 1'b1;
        tick();
        key_back = 1'b0;
    endtask

    task automatic press_enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic start_game(input logic [24:0] w);
        target   = w;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    task automatic eb_clear();
        for (int i = 0; i < 30; i++) eb[i] = 7'h1A;
    endtask

    task automatic eb_set(input int r, input int c, input logic [4:0] l, input logic [1:0] colr);
        eb[r*5 + c] = {colr, l};
    endtask

    task automatic expect_st(input string n, input int r, input int c,
                             input logic b, input logic w, input logic l);
        exp_t e;
        e.name = n;
        for (int i = 0; i < 30; i++) e.disp[7*i +: 7] = eb[i];
        e.row  = 3'(r);
        e.col  = 3'(c);
        e.busy = b;
        e.won  = w;
        e.lost = l;
        exp_q.push_back(e);
        @(negedge dclk);
    endtask

    task automatic chk(input string n, input logic [209:0] a, input logic [209:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // Monitor: owns the counters and the summary line
    initial begin
        exp_t e;
        forever begin
            @(negedge dclk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".display"}, display, e.disp);
                chk({e.name, ".row"}, 210'(cur_row), 210'(e.row));
                chk({e.name, ".col"}, 210'(cur_col), 210'(e.col));
                chk({e.name, ".busy"}, 210'(busy), 210'(e.busy));
                chk({e.name, ".won"}, 210'(game_won), 210'(e.won));
                chk({e.name, ".lost"}, 210'(game_lost), 210'(e.lost));
                $display("check %s row=%0d col=%0d busy=%0b won=%0b lost=%0b",
                         e.name, cur_row, cur_col, busy, game_won, game_lost);
            end
            if (done) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; new_game = 1'b0; target = 25'd0;
        key_valid = 1'b0; key_code = 5'd0; key_back = 1'b0; key_enter = 1'b0;
        repeat (3) tick();
        clr = 1'b0;
        tick();
        eb_clear();
        expect_st("reset", 0, 0, 0, 0, 0);

        // Game 1: target ABCDE, boundary keys, then a winning guess
        start_game(word(0, 1, 2, 3, 4));
        expect_st("ng1", 0, 0, 0, 0, 0);
        press_back();
        expect_st("back_col0", 0, 0, 0, 0, 0);
        press_letter(5'd27);
        expect_st("code27", 0, 0, 0, 0, 0);
        press_letter(5'd0);
        eb_set(0, 0, 5'd0, 2'd0);
        expect_st("letterA", 0, 1, 0, 0, 0);
        key_code = 5'd23; key_valid = 1'b1; key_back = 1'b1;
        tick();
        key_valid = 1'b0; key_back = 1'b0;
        eb_set(0, 0, 5'd26, 2'd0);
        expect_st("valid_back", 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            press_letter(5'(c));
            eb_set(0, c, 5'(c), 2'd0);
        end
        expect_st("row_full", 0, 5, 0, 0, 0);
        press_letter(5'd5);
        expect_st("sixth", 0, 5, 0, 0, 0);
        press_enter();
        repeat (6) tick();
        for (int c = 0; c < 5; c++) eb_set(0, c, 5'(c), 2'd1);
        expect_st("check_cyc", 0, 5, 1, 0, 0);
        tick();
        expect_st("won", 0, 5, 0, 1, 0);
        press_letter(5'd7);
        press_back();
        press_enter();
        repeat (3) tick();
        expect_st("frozen", 0, 5, 0, 1, 0);

        // Game 2: target ABBEY, guess BABBB -> 2,2,1,0,0
        start_game(word(0, 1, 1, 4, 24));
        eb_clear();
        expect_st("ng2", 0, 0, 0, 0, 0);
        press_letter(5'd1); press_letter(5'd0); press_letter(5'd1);
        press_letter(5'd1); press_letter(5'd1);
        press_enter();
        repeat (7) tick();
        eb_set(0, 0, 5'd1, 2'd2);
        eb_set(0, 1, 5'd0, 2'd2);
        eb_set(0, 2, 5'd1, 2'd1);
        eb_set(0, 3, 5'd1, 2'd0);
        eb_set(0, 4, 5'd1, 2'd0);
        expect_st("abbey", 1, 0, 0, 0, 0);

        // Short word rejection on row 1, letter typed during REJECT is dropped
        press_letter(5'd0); press_letter(5'd1);
        press_enter();
        eb_set(1, 0, 5'd0, 2'd3);
        eb_set(1, 1, 5'd1, 2'd3);
        expect_st("rej_start", 1, 2, 1, 0, 0);
        press_letter(5'd2);
        tick(); tick();
        expect_st("rej_end", 1, 2, 1, 0, 0);
        tick();
        eb_set(1, 0, 5'd0, 2'd0);
        eb_set(1, 1, 5'd1, 2'd0);
        expect_st("rej_done", 1, 2, 0, 0, 0);
        press_back(); press_back();
        eb_set(1, 0, 5'd26, 2'd0);
        eb_set(1, 1, 5'd26, 2'd0);
        expect_st("rej_back", 1, 0, 0, 0, 0);

        // Five more misses (FGHIJ shares nothing with ABBEY) -> lost at row 5
        for (int r = 1; r < 6; r++) begin
            for (int c = 0; c < 5; c++) begin
                press_letter(5'(5 + c));
                eb_set(r, c, 5'(5 + c), 2'd0);
            end
            press_enter();
            repeat (7) tick();
            if (r < 5) expect_st("miss", r + 1, 0, 0, 0, 0);
            else       expect_st("lost", 5, 5, 0, 0, 1);
        end

        // Game 3: new_game lands during YELLOW after some yellows were written
        start_game(word(0, 1, 2, 3, 4));
        eb_clear();
        expect_st("ng3", 0, 0, 0, 0, 0);
        press_letter(5'd4); press_letter(5'd0); press_letter(5'd1);
        press_letter(5'd2); press_letter(5'd3);
        press_enter();
        tick(); tick(); tick();
        start_game(word(0, 1, 2, 3, 4));
        expect_st("ng_mid", 0, 0, 0, 0, 0);
        repeat (10) tick();
        expect_st("ng_settle", 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            press_letter(5'(c));
            eb_set(0, c, 5'(c), 2'd1);
        end
        press_enter();
        repeat (7) tick();
        expect_st("won3", 0, 5, 0, 1, 0);

        done = 1'b1;
    end

endmodule
